// File: rtl/wave_drawer_pkg.sv
// Shared types and screen geometry for the waveform drawer.
package wave_drawer_pkg;

    // Controller phases: wait for start, plot a frame, hold it, then erase it.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_IDLE  = 2'd2,
        ST_ERASE = 2'd3
    } state_t;

    localparam int SCREEN_H = 480;
    localparam int Y_CENTER = 240;
    localparam int X_BITS   = 10;
    localparam int Y_BITS   = 9;

endpackage

// File: rtl/wave_drawer_if.sv
// Sample input and pixel output bundle of the waveform drawer.
interface wave_drawer_if #(
    parameter int WIDTH = 24
);
    import wave_drawer_pkg::*;

    logic                     start;
    logic                     enable;
    logic signed [WIDTH-1:0]  wave_signal;
    logic                     pen;
    logic [X_BITS-1:0]        x;
    logic [Y_BITS-1:0]        y;

    // Sample source / pixel consumer side.
    modport master (
        output start, enable, wave_signal,
        input  pen, x, y
    );

    // Drawer side.
    modport slave (
        input  start, enable, wave_signal,
        output pen, x, y
    );

endinterface

// File: rtl/wave_drawer_avg_filter.sv
// N-tap moving-average filter: running sum over a shift register of taps.
module wave_avg_filter #(
    parameter int WIDTH = 24,
    parameter int N     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] avg
);
    localparam int LOG2N = $clog2(N);
    localparam int SUM_W = WIDTH + LOG2N;

    logic signed [WIDTH-1:0] taps_reg [N];
    logic signed [SUM_W-1:0] sum_reg;
    logic signed [SUM_W-1:0] sample_ext;
    logic signed [SUM_W-1:0] oldest_ext;

    // Sign-extend the entering and leaving samples to the accumulator width.
    assign sample_ext = {{LOG2N{sample[WIDTH-1]}}, sample};
    assign oldest_ext = {{LOG2N{taps_reg[N-1][WIDTH-1]}}, taps_reg[N-1]};

    // Shift a new sample in; taps hold when enable is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) taps_reg[i] <= '0;
        end else if (enable) begin
            taps_reg[0] <= sample;
            for (int i = 1; i < N; i++) taps_reg[i] <= taps_reg[i-1];
        end
    end

    // Running sum: add the newcomer, drop the sample falling off the end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_reg <= '0;
        end else if (enable) begin
            sum_reg <= sum_reg + sample_ext - oldest_ext;
        end
    end

    // Divide by N; the mean of WIDTH-bit samples always fits in WIDTH bits.
    assign avg = WIDTH'(sum_reg >>> LOG2N);

endmodule

// File: rtl/wave_drawer_core.sv
// Waveform drawer: filters audio, plots one column per cycle, holds, then
// erases the same frame by replaying the stored rows.
module wave_drawer_core
    import wave_drawer_pkg::*;
#(
    parameter int WIDTH       = 24,
    parameter int BUFFER_SIZE = 640,
    parameter int DIV         = 15,
    parameter int DURATION    = 10,
    parameter int N           = 16
) (
    input  logic         clk,
    input  logic         reset,
    wave_drawer_if.slave bus
);
    localparam int IDLE_W = (DURATION > 1) ? $clog2(DURATION) : 1;
    localparam int ROW_W  = ((WIDTH > X_BITS) ? WIDTH : X_BITS) + 2;

    state_t                  state_reg, state_next;
    logic [X_BITS-1:0]       col_reg, col_next;
    logic [IDLE_W-1:0]       idle_reg, idle_next;
    logic signed [WIDTH-1:0] filt_out;
    logic signed [ROW_W-1:0] offset;
    logic signed [ROW_W-1:0] row_s;
    logic [Y_BITS-1:0]       row;
    logic [Y_BITS-1:0]       line_buf [BUFFER_SIZE];
    logic                    buf_we;
    logic                    done;
    logic                    invalidate;
    logic                    pen_c;
    logic [X_BITS-1:0]       x_c;
    logic [Y_BITS-1:0]       y_c;

    wave_avg_filter #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_filt (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .sample (bus.wave_signal),
        .avg    (filt_out)
    );

    // Map filtered amplitude to a screen row: positive swings go up.
    assign offset = ROW_W'(filt_out >>> DIV);
    assign row_s  = ROW_W'(Y_CENTER) - offset;

    // Keep the row on screen.
    always_comb begin
        row = '0;
        if (row_s < 0)
            row = '0;
        else if (row_s > ROW_W'(SCREEN_H - 1))
            row = Y_BITS'(SCREEN_H - 1);
        else
            row = row_s[Y_BITS-1:0];
    end

    assign done       = (col_reg == X_BITS'(BUFFER_SIZE - 1));
    assign invalidate = (idle_reg == IDLE_W'(DURATION - 1));

    // State, column and hold counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_INIT;
            col_reg   <= '0;
            idle_reg  <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            idle_reg  <= idle_next;
        end
    end

    // Remember each drawn row; read asynchronously so erase has no latency.
    always_ff @(posedge clk) begin
        if (buf_we) line_buf[col_reg] <= row;
    end

    // Next-state logic and pixel outputs.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        idle_next  = idle_reg;
        buf_we     = 1'b0;
        pen_c      = 1'b0;
        x_c        = '0;
        y_c        = '0;
        case (state_reg)
            ST_INIT: begin
                if (bus.start) state_next = ST_DRAW;
            end
            ST_DRAW: begin
                pen_c  = 1'b1;
                x_c    = col_reg;
                y_c    = row;
                buf_we = 1'b1;
                if (done) begin
                    col_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    col_next = col_reg + X_BITS'(1);
                end
            end
            ST_IDLE: begin
                if (invalidate) begin
                    idle_next  = '0;
                    state_next = ST_ERASE;
                end else begin
                    idle_next = idle_reg + IDLE_W'(1);
                end
            end
            ST_ERASE: begin
                x_c = col_reg;
                y_c = line_buf[col_reg];
                if (done) begin
                    col_next   = '0;
                    state_next = ST_DRAW;
                end else begin
                    col_next = col_reg + X_BITS'(1);
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign bus.pen = pen_c;
    assign bus.x   = x_c;
    assign bus.y   = y_c;

endmodule

// File: tb/tb_wave_drawer_core.sv
// Bench for wave_drawer_core: frame-period model plus directed literal checks.
module tb_wave_drawer_core;
    localparam int B      = 640;
    localparam int D      = 10;
    localparam int NT     = 16;
    localparam int PERIOD = 2 * B + D;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wave_drawer_if #(.WIDTH(24)) bus ();

    wave_drawer_core #(
        .WIDTH       (24),
        .BUFFER_SIZE (B),
        .DIV         (15),
        .DURATION    (D),
        .N           (NT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: frame position is time since entering DRAW modulo the period.
    bit     m_valid = 1'b0;
    bit     m_run   = 1'b0;
    int     m_t     = 0;
    longint m_taps [NT];
    int     m_drawn [B];

    function automatic longint m_filt();
        longint s = 0;
        for (int i = 0; i < NT; i++) s += m_taps[i];
        return s >>> 4;
    endfunction

    function automatic int y_of(longint f);
        longint r = 240 - (f >>> 15);
        if (r < 0) r = 0;
        if (r > 479) r = 479;
        return int'(r);
    endfunction

    // Compare on the falling edge, then advance the model over the next rising edge.
    always @(negedge clk) begin
        int p, ep, ex, ey;
        if (m_valid) begin
            ep = 0; ex = 0; ey = 0;
            if (m_run) begin
                p = m_t % PERIOD;
                if (p < B) begin
                    ep = 1; ex = p; ey = y_of(m_filt());
                end else if (p >= B + D) begin
                    ex = p - B - D; ey = m_drawn[p - B - D];
                end
            end
            checks++;
            if (int'(bus.pen) != ep || int'(bus.x) != ex || int'(bus.y) != ey) begin
                errors++;
                $display("FAIL model t=%0d pen/x/y got %0d/%0d/%0d want %0d/%0d/%0d",
                         m_t, bus.pen, bus.x, bus.y, ep, ex, ey);
            end
        end
        if (!reset) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_t     = 0;
            for (int i = 0; i < NT; i++) m_taps[i] = 0;
        end else if (m_valid) begin
            if (m_run) begin
                p = m_t % PERIOD;
                if (p < B) m_drawn[p] = y_of(m_filt());
                m_t++;
            end else if (bus.start) begin
                m_run = 1'b1;
                m_t   = 0;
            end
            if (bus.enable) begin
                for (int i = NT - 1; i > 0; i--) m_taps[i] = m_taps[i-1];
                m_taps[0] = longint'(bus.wave_signal);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    int vals [3] = '{8388607, -8388608, 32768};
    int rows [3] = '{0, 479, 239};

    initial begin
        bus.start       = 1'b0;
        bus.enable      = 1'b0;
        bus.wave_signal = '0;
        reset           = 1'b0;
        step(2);
        reset = 1'b1;
        check("rst_pen", bus.pen, 0);
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("init_pen", bus.pen, 0);
        end
        $display("phase reset/init done");

        // Filter ramp from zero state with constant 16.
        bus.enable      = 1'b1;
        bus.wave_signal = 24'sd16;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check("filt_ramp", dut.filt_out, k);
            check("model_filt", m_filt(), k);
        end
        step(4);
        check("filt_steady", dut.filt_out, 16);
        bus.enable      = 1'b0;
        bus.wave_signal = 24'sd12345;
        step(3);
        check("filt_hold", dut.filt_out, 16);
        $display("phase filter done");

        // Full frame cycle with silent input.
        do_reset();
        bus.wave_signal = '0;
        bus.enable      = 1'b1;
        bus.start       = 1'b1;
        step(1);
        check("draw0_pen", bus.pen, 1);
        check("draw0_x", bus.x, 0);
        check("draw0_y", bus.y, 240);
        step(639);
        check("draw639_x", bus.x, 639);
        step(1);
        check("idle_pen", bus.pen, 0);
        check("idle_x", bus.x, 0);
        step(10);
        check("erase0_pen", bus.pen, 0);
        check("erase0_y", bus.y, 240);
        step(639);
        check("erase639_x", bus.x, 639);
        step(1);
        check("redraw_pen", bus.pen, 1);
        check("redraw_x", bus.x, 0);
        bus.start = 1'b0;
        $display("phase frame done");

        // Row clamping at the extremes.
        for (int i = 0; i < 3; i++) begin
            do_reset();
            bus.wave_signal = vals[i];
            bus.enable      = 1'b1;
            bus.start       = 1'b0;
            step(16);
            bus.start = 1'b1;
            step(1);
            check("clamp_pen", bus.pen, 1);
            check("clamp_y", bus.y, rows[i]);
            step(3);
            check("clamp_y_hold", bus.y, rows[i]);
            $display("clamp input %0d checked", vals[i]);
        end

        // Ramp during draw; the model checks erase replays the drawn rows.
        do_reset();
        bus.wave_signal = '0;
        bus.enable      = 1'b1;
        bus.start       = 1'b1;
        step(1);
        for (int i = 0; i < B + D + B; i++) begin
            bus.wave_signal = bus.wave_signal + 24'sd32768;
            step(1);
        end
        $display("phase replay done");

        // Reset in the middle of a frame.
        do_reset();
        bus.enable = 1'b0;
        bus.start  = 1'b1;
        step(101);
        check("mid_x", bus.x, 100);
        reset = 1'b0;
        step(1);
        reset     = 1'b1;
        bus.start = 1'b0;
        check("abort_pen", bus.pen, 0);
        check("abort_x", bus.x, 0);
        step(5);
        check("stay_init_pen", bus.pen, 0);
        bus.start = 1'b1;
        step(1);
        check("restart_pen", bus.pen, 1);
        check("restart_x", bus.x, 0);
        step(2);
        check("restart_x2", bus.x, 2);
        $display("phase abort done");

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_drawer_core.md
WAVE_DRAWER_CORE -- requirements
Module: wave_drawer_core

Interface
REQ-001 SHALL have parameter WIDTH, default 24: sample width in bits, signed two's complement.
REQ-002 SHALL have parameter BUFFER_SIZE, default 640: waveform columns per frame, legal range 2..640.
REQ-003 SHALL have parameter DIV, default 15: arithmetic right-shift from sample to pixel offset.
REQ-004 SHALL have parameter DURATION, default 10: IDLE hold length in cycles between draw and erase, minimum 1.
REQ-005 SHALL have parameter N, default 16: moving-average window length, power of two, minimum 2.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: level; starts drawing, sampled only in INIT.
REQ-009 SHALL have port enable, input, 1 bit: filter sample strobe.
REQ-010 SHALL have port wave_signal, input, WIDTH bits signed: audio sample.
REQ-011 SHALL have port pen, output, 1 bit: 1 = plot (x,y), 0 = erase or no-op.
REQ-012 SHALL have port x, output, 10 bits: pixel column.
REQ-013 SHALL have port y, output, 9 bits: pixel row.

Function
REQ-014 The filter SHALL keep the last N accepted samples and a running sum of WIDTH+log2(N) bits; on an edge with enable=1 it SHALL shift in wave_signal and update sum = sum + new - oldest.
REQ-015 Filter output SHALL be sum arithmetically shifted right by log2(N), truncated to WIDTH bits, valid immediately after the accepting edge; enable=0 SHALL hold taps and sum.
REQ-016 Pixel row SHALL be 240 - (filtered >>> DIV), computed signed, clamped to 0..479.
REQ-017 Controller states SHALL be INIT, DRAW, IDLE, ERASE; column counter col SHALL run 0..BUFFER_SIZE-1; done = (col == BUFFER_SIZE-1); invalidate = (idle counter == DURATION-1).
REQ-018 INIT: pen=0, x=0, y=0, col=0; INIT->DRAW on an edge with start=1, otherwise stay.
REQ-019 DRAW: each cycle pen=1, x=col, y=REQ-016 value of the current filter output; that y SHALL be written to line buffer entry col on the edge; col increments; on done col->0 and state->IDLE.
REQ-020 IDLE: pen=0, x=0, y=0; idle counter increments each cycle; on invalidate counter->0 and state->ERASE.
REQ-021 ERASE: each cycle pen=0, x=col, y=buffer[col]; col increments; on done col->0 and state->DRAW.
REQ-022 After the first start the cycle DRAW->IDLE->ERASE->DRAW SHALL repeat indefinitely; start is ignored outside INIT.
REQ-023 Outputs x, y, pen SHALL be combinational from state, col, buffer and filter output (zero-cycle latency).
REQ-024 The datapath SHALL sample the filter output every DRAW cycle regardless of enable.

Reset
REQ-025 With reset=0 at an edge: state=INIT, col=0, idle counter=0, filter taps and sum=0; pen=0, x=0, y=0 after that edge.
REQ-026 Reset asserted mid-DRAW/IDLE/ERASE SHALL abort the frame; line buffer contents need not be cleared.

Structure
REQ-027 Package wave_drawer_pkg SHALL hold the state enum and constants SCREEN_H=480, Y_CENTER=240, X_BITS=10, Y_BITS=9.
REQ-028 The moving-average filter SHALL be one sub-module, wave_avg_filter (params WIDTH, N); controller and datapath live in wave_drawer_core.

Verification
REQ-029 reset=0 one cycle, then start=0 for 5 cycles -> pen=0, x=0, y=0 throughout.
REQ-030 wave_signal=0, enable=1, start=1 -> 640 cycles pen=1, x=0..639, y=240; then 10 cycles pen=0; then 640 cycles pen=0, x=0..639, y=240; then DRAW restarts at x=0.
REQ-031 Filter: enable=1, wave_signal=16 constant from zero state -> output 1,2,...,16 after edges 1..16, stays 16; enable=0 holds 16 with any input.
REQ-032 Clamp: steady wave_signal=8388607 -> y=0; steady -8388608 -> y=479; steady 32768 -> y=239.
REQ-033 Replay: ramp wave_signal (+1 per cycle, step 2^15) during DRAW -> during ERASE, y at each x equals y drawn at that x.
REQ-034 reset=0 at DRAW x=100 -> pen=0, x=0; stays INIT until start=1, then DRAW from x=0.
